// File: rtl/axi4lite_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register slave.
package axi4lite_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle; clock and active-high reset enter as interface ports.
interface axi4lite_if
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic A_CLK,
  input logic A_RSTn
);

  logic [ADDR_WIDTH-1:0]   AW_ADDR;
  logic [2:0]              AW_PROT;
  logic                    AW_VALID;
  logic                    AW_READY;
  logic [DATA_WIDTH-1:0]   W_DATA;
  logic [DATA_WIDTH/8-1:0] W_STRB;
  logic                    W_VALID;
  logic                    W_READY;
  logic [1:0]              B_RESP;
  logic                    B_VALID;
  logic                    B_READY;
  logic [ADDR_WIDTH-1:0]   AR_ADDR;
  logic [2:0]              AR_PROT;
  logic                    AR_VALID;
  logic                    AR_READY;
  logic [DATA_WIDTH-1:0]   R_DATA;
  logic [1:0]              R_RESP;
  logic                    R_VALID;
  logic                    R_READY;

  modport master (
    input  A_CLK, A_RSTn,
    output AW_ADDR, AW_PROT, AW_VALID, input AW_READY,
    output W_DATA, W_STRB, W_VALID, input W_READY,
    input  B_RESP, B_VALID, output B_READY,
    output AR_ADDR, AR_PROT, AR_VALID, input AR_READY,
    input  R_DATA, R_RESP, R_VALID, output R_READY
  );

  modport slave (
    input  A_CLK, A_RSTn,
    input  AW_ADDR, AW_PROT, AW_VALID, output AW_READY,
    input  W_DATA, W_STRB, W_VALID, output W_READY,
    output B_RESP, B_VALID, input B_READY,
    input  AR_ADDR, AR_PROT, AR_VALID, output AR_READY,
    output R_DATA, R_RESP, R_VALID, input R_READY
  );

endinterface

// File: rtl/axi4lite_regfile.sv
// Register array with a byte-strobed write port and a registered read port.
module axi4lite_regfile
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic                    rd_hit,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage: cleared on reset, strobed byte lanes updated on write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read capture samples the old contents when a write lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= rd_hit ? mem_r[rd_idx] : {DATA_WIDTH{1'b0}};
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite register slave: independent write/read FSMs in front of a register file.
module axi4lite_slave
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  axi4lite_if.slave bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * NUM_REGS);

  wr_state_e wr_state_r, wr_state_nxt_s;
  rd_state_e rd_state_r, rd_state_nxt_s;

  logic                    aw_ready_r, w_ready_r, b_valid_r;
  logic [1:0]              b_resp_r;
  logic                    ar_ready_r, r_valid_r;
  logic [1:0]              r_resp_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [DATA_WIDTH/8-1:0] strb_r;

  logic                    aw_hs_s, w_hs_s, ar_hs_s;
  logic                    wr_commit_s, wr_hit_s, rd_hit_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [DATA_WIDTH/8-1:0] wr_strb_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic                    unused_prot_s;

  assign unused_prot_s = ^{bus.AW_PROT, bus.AR_PROT};

  assign aw_hs_s  = bus.AW_VALID & aw_ready_r;
  assign w_hs_s   = bus.W_VALID  & w_ready_r;
  assign ar_hs_s  = bus.AR_VALID & ar_ready_r;
  assign wr_hit_s = (wr_addr_s < ADDR_LIMIT);
  assign rd_hit_s = (bus.AR_ADDR < ADDR_LIMIT);

  // Write sequencing: decide commit and pick live or captured address/data.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wr_commit_s    = 1'b0;
    wr_addr_s      = addr_r;
    wr_data_s      = data_r;
    wr_strb_s      = strb_r;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          wr_commit_s    = 1'b1;
          wr_addr_s      = bus.AW_ADDR;
          wr_data_s      = bus.W_DATA;
          wr_strb_s      = bus.W_STRB;
          wr_state_nxt_s = WR_RESP;
        end else if (aw_hs_s) begin
          wr_state_nxt_s = WR_WAIT_W;
        end else if (w_hs_s) begin
          wr_state_nxt_s = WR_WAIT_AW;
        end else begin
          wr_state_nxt_s = WR_IDLE;
        end
      end
      WR_WAIT_W: begin
        if (w_hs_s) begin
          wr_commit_s    = 1'b1;
          wr_data_s      = bus.W_DATA;
          wr_strb_s      = bus.W_STRB;
          wr_state_nxt_s = WR_RESP;
        end else begin
          wr_state_nxt_s = WR_WAIT_W;
        end
      end
      WR_WAIT_AW: begin
        if (aw_hs_s) begin
          wr_commit_s    = 1'b1;
          wr_addr_s      = bus.AW_ADDR;
          wr_state_nxt_s = WR_RESP;
        end else begin
          wr_state_nxt_s = WR_WAIT_AW;
        end
      end
      WR_RESP: begin
        if (bus.B_READY) begin
          wr_state_nxt_s = WR_IDLE;
        end else begin
          wr_state_nxt_s = WR_RESP;
        end
      end
      default: wr_state_nxt_s = WR_IDLE;
    endcase
  end

  // Write state and its outputs; readies stay low until the first edge out of reset.
  always_ff @(posedge bus.A_CLK or posedge bus.A_RSTn) begin
    if (bus.A_RSTn) begin
      wr_state_r <= WR_IDLE;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      b_resp_r   <= RESP_OKAY;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      data_r     <= {DATA_WIDTH{1'b0}};
      strb_r     <= {(DATA_WIDTH/8){1'b0}};
    end else begin
      wr_state_r <= wr_state_nxt_s;
      aw_ready_r <= (wr_state_nxt_s == WR_IDLE) || (wr_state_nxt_s == WR_WAIT_AW);
      w_ready_r  <= (wr_state_nxt_s == WR_IDLE) || (wr_state_nxt_s == WR_WAIT_W);
      b_valid_r  <= (wr_state_nxt_s == WR_RESP);
      if (wr_commit_s) begin
        b_resp_r <= wr_hit_s ? RESP_OKAY : RESP_SLVERR;
      end
      if (aw_hs_s) begin
        addr_r <= bus.AW_ADDR;
      end
      if (w_hs_s) begin
        data_r <= bus.W_DATA;
        strb_r <= bus.W_STRB;
      end
    end
  end

  // Read sequencing.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: rd_state_nxt_s = ar_hs_s ? RD_DATA : RD_IDLE;
      RD_DATA: rd_state_nxt_s = bus.R_READY ? RD_IDLE : RD_DATA;
      default: rd_state_nxt_s = RD_IDLE;
    endcase
  end

  // Read state and its outputs.
  always_ff @(posedge bus.A_CLK or posedge bus.A_RSTn) begin
    if (bus.A_RSTn) begin
      rd_state_r <= RD_IDLE;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_resp_r   <= RESP_OKAY;
    end else begin
      rd_state_r <= rd_state_nxt_s;
      ar_ready_r <= (rd_state_nxt_s == RD_IDLE);
      r_valid_r  <= (rd_state_nxt_s == RD_DATA);
      if (ar_hs_s) begin
        r_resp_r <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axi4lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (bus.A_CLK),
    .rst     (bus.A_RSTn),
    .wr_en   (wr_commit_s & wr_hit_s),
    .wr_idx  (wr_addr_s[IDX_W+1:2]),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_en   (ar_hs_s),
    .rd_hit  (rd_hit_s),
    .rd_idx  (bus.AR_ADDR[IDX_W+1:2]),
    .rd_data (rd_data_s)
  );

  assign bus.AW_READY = aw_ready_r;
  assign bus.W_READY  = w_ready_r;
  assign bus.B_VALID  = b_valid_r;
  assign bus.B_RESP   = b_resp_r;
  assign bus.AR_READY = ar_ready_r;
  assign bus.R_VALID  = r_valid_r;
  assign bus.R_RESP   = r_resp_r;
  assign bus.R_DATA   = rd_data_s;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Directed bench for axi4lite_slave: inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.A_CLK(clk), .A_RSTn(rst));

  axi4lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (.bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    @(negedge clk);
    bus.AR_ADDR  = addr;
    bus.AR_VALID = 1'b1;
    check({tag, " ar_ready"}, 32'(bus.AR_READY), 32'd1);
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    check({tag, " r_valid"}, 32'(bus.R_VALID), 32'd1);
    check({tag, " r_data"}, bus.R_DATA, exp_data);
    check({tag, " r_resp"}, 32'(bus.R_RESP), 32'(exp_resp));
    bus.R_READY = 1'b1;
    @(negedge clk);
    check({tag, " r_valid drop"}, 32'(bus.R_VALID), 32'd0);
    bus.R_READY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    @(negedge clk);
    bus.AW_ADDR  = addr;
    bus.AW_VALID = 1'b1;
    bus.W_DATA   = data;
    bus.W_STRB   = strb;
    bus.W_VALID  = 1'b1;
    check({tag, " aw_ready"}, 32'(bus.AW_READY), 32'd1);
    check({tag, " w_ready"}, 32'(bus.W_READY), 32'd1);
    @(negedge clk);
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    check({tag, " b_valid"}, 32'(bus.B_VALID), 32'd1);
    check({tag, " b_resp"}, 32'(bus.B_RESP), 32'(exp_resp));
    bus.B_READY = 1'b1;
    @(negedge clk);
    check({tag, " b_valid drop"}, 32'(bus.B_VALID), 32'd0);
    bus.B_READY = 1'b0;
  endtask

  initial begin
    bus.AW_ADDR = 32'd0; bus.AW_PROT = 3'd0; bus.AW_VALID = 1'b0;
    bus.W_DATA  = 32'd0; bus.W_STRB  = 4'd0; bus.W_VALID  = 1'b0;
    bus.B_READY = 1'b0;
    bus.AR_ADDR = 32'd0; bus.AR_PROT = 3'd0; bus.AR_VALID = 1'b0;
    bus.R_READY = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst aw_ready", 32'(bus.AW_READY), 32'd0);
    check("rst w_ready", 32'(bus.W_READY), 32'd0);
    check("rst ar_ready", 32'(bus.AR_READY), 32'd0);
    check("rst b_valid", 32'(bus.B_VALID), 32'd0);
    check("rst r_valid", 32'(bus.R_VALID), 32'd0);
    check("rst r_data", bus.R_DATA, 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst aw_ready before edge", 32'(bus.AW_READY), 32'd0);
    @(negedge clk);
    check("post-rst aw_ready", 32'(bus.AW_READY), 32'd1);
    check("post-rst w_ready", 32'(bus.W_READY), 32'd1);
    check("post-rst ar_ready", 32'(bus.AR_READY), 32'd1);

    axi_read(32'h1, 32'h0, 2'b00, "rd 0x1");
    axi_write(32'h1, 32'h1, 4'h0, 2'b00, "wr strb0");
    axi_read(32'h0, 32'h0, 2'b00, "rd after strb0");

    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, "wr full");
    axi_write(32'h4, 32'h000000AA, 4'h1, 2'b00, "wr byte0");
    axi_read(32'h4, 32'hDEADBEAA, 2'b00, "rd merged");

    // AW first, W three cycles later, then a stalled response
    @(negedge clk);
    bus.AW_ADDR  = 32'h8;
    bus.AW_VALID = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("waitw aw_ready", 32'(bus.AW_READY), 32'd0);
      check("waitw w_ready", 32'(bus.W_READY), 32'd1);
      check("waitw b_valid", 32'(bus.B_VALID), 32'd0);
      if (i < 2) @(negedge clk);
    end
    bus.W_DATA  = 32'h12345678;
    bus.W_STRB  = 4'hF;
    bus.W_VALID = 1'b1;
    @(negedge clk);
    bus.W_VALID = 1'b0;
    check("aw-first b_valid", 32'(bus.B_VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall b_valid", 32'(bus.B_VALID), 32'd1);
      check("stall b_resp", 32'(bus.B_RESP), 32'd0);
      check("stall aw_ready", 32'(bus.AW_READY), 32'd0);
    end
    bus.B_READY = 1'b1;
    @(negedge clk);
    check("stall release", 32'(bus.B_VALID), 32'd0);
    bus.B_READY = 1'b0;
    axi_read(32'h8, 32'h12345678, 2'b00, "rd aw-first");

    // W first, AW two cycles later, two low byte lanes
    @(negedge clk);
    bus.W_DATA  = 32'hCAFEF00D;
    bus.W_STRB  = 4'h3;
    bus.W_VALID = 1'b1;
    @(negedge clk);
    bus.W_VALID = 1'b0;
    check("waitaw w_ready", 32'(bus.W_READY), 32'd0);
    check("waitaw aw_ready", 32'(bus.AW_READY), 32'd1);
    @(negedge clk);
    bus.AW_ADDR  = 32'hC;
    bus.AW_VALID = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0;
    check("w-first b_valid", 32'(bus.B_VALID), 32'd1);
    bus.B_READY = 1'b1;
    @(negedge clk);
    bus.B_READY = 1'b0;
    axi_read(32'hC, 32'h0000F00D, 2'b00, "rd w-first");

    // Range boundaries
    axi_read(32'h40, 32'h0, 2'b10, "rd oor");
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, "wr oor");
    axi_read(32'h0, 32'h0, 2'b00, "rd 0 after oor");
    axi_read(32'h4, 32'hDEADBEAA, 2'b00, "rd 4 after oor");
    axi_read(32'h3C, 32'h0, 2'b00, "rd last");
    axi_write(32'h3F, 32'h00000055, 4'hF, 2'b00, "wr last unaligned");
    axi_read(32'h3C, 32'h00000055, 2'b00, "rd last after wr");

    // Read accepted in the same cycle as a write commit to the same register
    @(negedge clk);
    bus.AW_ADDR = 32'h4; bus.AW_VALID = 1'b1;
    bus.W_DATA = 32'h11111111; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
    bus.AR_ADDR = 32'h4; bus.AR_VALID = 1'b1;
    @(negedge clk);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    check("concurrent b_valid", 32'(bus.B_VALID), 32'd1);
    check("concurrent r_valid", 32'(bus.R_VALID), 32'd1);
    check("concurrent r_data old", bus.R_DATA, 32'hDEADBEAA);
    bus.B_READY = 1'b1; bus.R_READY = 1'b1;
    @(negedge clk);
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;
    axi_read(32'h4, 32'h11111111, 2'b00, "rd after concurrent");

    // Asynchronous reset while R_VALID is high
    @(negedge clk);
    bus.AR_ADDR = 32'h4; bus.AR_VALID = 1'b1;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    check("pre-rst r_valid", 32'(bus.R_VALID), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async rst r_valid", 32'(bus.R_VALID), 32'd0);
    check("async rst r_data", bus.R_DATA, 32'd0);
    check("async rst ar_ready", 32'(bus.AR_READY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_read(32'h4, 32'h0, 2'b00, "rd 4 after rst");
    axi_read(32'h8, 32'h0, 2'b00, "rd 8 after rst");
    axi_read(32'h3C, 32'h0, 2'b00, "rd 3C after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
